ram_rd_checker: RTL

Read-side companion of the dual-port RAM writer in the ip_2port_ram test design. Once the writer raises rd_flag, this block sweeps the RAM read port continuously, 0..DEPTH-1 with wrap-around. It compares each returned word against the pattern the writer stores, which is the zero-extended address. It reports sticky error status, a saturating error count, the first failing address and a completed-pass count, for on-board LEDs or a logic analyser.

---
 rtl/ram_rd_checker_if.sv | 26 ++
 rtl/ram_rd_checker.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/ram_rd_checker_if.sv
// ram_rd_checker_if
// Read port of the dual-port test RAM, seen from the checker (master) and from
// the RAM (slave).
//   ram_rd_en    : read enable, driven by the checker
//   ram_rd_addr  : read address, driven by the checker
//   ram_rd_data  : read data, driven by the RAM a fixed latency after the address
interface ram_rd_checker_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
);
    logic              ram_rd_en;
    logic [ADDR_W-1:0] ram_rd_addr;
    logic [DATA_W-1:0] ram_rd_data;

    modport master (
        output ram_rd_en,
        output ram_rd_addr,
        input  ram_rd_data
    );

    modport slave (
        input  ram_rd_en,
        input  ram_rd_addr,
        output ram_rd_data
    );
endinterface

// File: rtl/ram_rd_checker.sv
// ram_rd_checker
// Read-side companion of the dual-port RAM writer. Once rd_flag is raised it
// sweeps the RAM read port 0..DEPTH-1 with wrap-around and compares every
// returned word with the pattern the writer stores (the zero-extended address).
// Status is intended for LEDs or a logic analyser.
// Ports:
//   clk            : system clock
//   rst_n          : asynchronous active-low reset
//   rd_flag        : start/continue request from the writer (level, sampled at
//                    the start and at the last address of each sweep)
//   ram            : RAM read port (enable, address, data)
//   rd_data_vld    : ram.ram_rd_data is a checked sample this cycle
//   err_flag       : sticky, at least one mismatch seen since reset
//   err_cnt        : mismatch count, saturating at 255
//   first_err_addr : address of the first mismatch since reset
//   pass_cnt       : completed sweeps, wraps modulo 2**16
//   busy           : high while reading or draining the read pipeline
module ram_rd_checker #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64,
    parameter int RD_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rd_flag,
    ram_rd_checker_if.master     ram,
    output logic                 rd_data_vld,
    output logic                 err_flag,
    output logic [7:0]           err_cnt,
    output logic [ADDR_W-1:0]    first_err_addr,
    output logic [15:0]          pass_cnt,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
    localparam logic [1:0]        DRAIN_LAST = 2'(RD_LAT - 1);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addr_next;
    logic [1:0]        drain_cnt;
    logic [1:0]        drain_next;

    // {valid, addr} travels alongside the RAM access so each returned word
    // arrives together with the address it was read from.
    logic              pipe_vld  [RD_LAT];
    logic [ADDR_W-1:0] pipe_addr [RD_LAT];
    logic [ADDR_W-1:0] exp_addr;
    logic              mismatch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr      <= '0;
            drain_cnt <= '0;
        end else begin
            state     <= state_next;
            addr      <= addr_next;
            drain_cnt <= drain_next;
        end
    end

    // rd_flag only matters in IDLE and at the last address of a sweep, so a
    // request dropped mid-pass always lets the pass finish. DRAIN lasts RD_LAT
    // cycles, which is exactly the time for the last read to come back.
    always_comb begin
        state_next = state;
        addr_next  = addr;
        drain_next = drain_cnt;
        case (state)
            IDLE: begin
                addr_next = '0;
                if (rd_flag) begin
                    state_next = READ;
                end
            end
            READ: begin
                if (addr == LAST_ADDR) begin
                    addr_next = '0;
                    if (!rd_flag) begin
                        state_next = DRAIN;
                        drain_next = '0;
                    end
                end else begin
                    addr_next = addr + ADDR_W'(1);
                end
            end
            DRAIN: begin
                if (drain_cnt == DRAIN_LAST) begin
                    state_next = IDLE;
                    drain_next = '0;
                end else begin
                    drain_next = drain_cnt + 2'd1;
                end
            end
            default: begin
                state_next = IDLE;
                addr_next  = '0;
                drain_next = '0;
            end
        endcase
    end

    assign ram.ram_rd_en   = (state == READ);
    assign ram.ram_rd_addr = addr;
    assign busy            = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_vld[i]  <= 1'b0;
                pipe_addr[i] <= '0;
            end
        end else begin
            pipe_vld[0]  <= ram.ram_rd_en;
            pipe_addr[0] <= ram.ram_rd_addr;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_addr[i] <= pipe_addr[i-1];
            end
        end
    end

    assign rd_data_vld = pipe_vld[RD_LAT-1];
    assign exp_addr    = pipe_addr[RD_LAT-1];
    assign mismatch    = (ram.ram_rd_data != DATA_W'(exp_addr));

    // first_err_addr is captured only while err_flag is still clear, so it
    // keeps the very first failure until reset. The pass counter ticks on the
    // last word of a sweep whether or not that word was correct.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_flag       <= 1'b0;
            err_cnt        <= '0;
            first_err_addr <= '0;
            pass_cnt       <= '0;
        end else if (rd_data_vld) begin
            if (mismatch) begin
                err_flag <= 1'b1;
                if (err_cnt != 8'hFF) begin
                    err_cnt <= err_cnt + 8'd1;
                end
                if (!err_flag) begin
                    first_err_addr <= exp_addr;
                end
            end
            if (exp_addr == LAST_ADDR) begin
                pass_cnt <= pass_cnt + 16'd1;
            end
        end
    end

endmodule
